// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcode encodings,
// the muldiv state encoding and the default datapath width.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle on a shared 2*WIDTH
// accumulator, followed by a sign-fix cycle that commits HI/LO.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter bit PROTOCOL_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg_w(v) : v;
  endfunction

  muldiv_state_e      state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   m_q, m_d;         // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;     // negate product / quotient
  logic               rneg_q, rneg_d;   // negate remainder
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               div_zero;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;

  assign signed_op = ~op[0];
  assign div_zero  = (opb == '0);

  // Single datapath step shared by both iterations, plus the sign-fixed product.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};
    prod_fix  = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
  end

  // Next-state logic: operation launch, iteration, sign fix, MTHI/MTLO and flush.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          is_div_d = op[1];
          count_d  = '0;
          state_d  = ST_ITER;
          if (op[1]) begin
            // A zero divisor runs the raw dividend unsigned: the restoring
            // loop then yields quotient all-ones and remainder = dividend.
            if (div_zero) begin
              acc_d  = {{WIDTH{1'b0}}, opa};
              m_d    = '0;
              neg_d  = 1'b0;
              rneg_d = 1'b0;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, signed_op ? abs_w(opa) : opa};
              m_d    = signed_op ? abs_w(opb) : opb;
              neg_d  = signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
              rneg_d = signed_op & opa[WIDTH-1];
            end
          end else begin
            acc_d  = {{WIDTH{1'b0}}, signed_op ? abs_w(opb) : opb};
            m_d    = signed_op ? abs_w(opa) : opa;
            neg_d  = signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rneg_d = 1'b0;
          end
        end else if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_ITER: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q  ? neg_w(acc_q[WIDTH-1:0])       : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort an in-flight operation: HI/LO keep their committed values.
    if (flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign stall = busy | start;

  // The pipeline is frozen while busy, so neither a new start nor an MTHI/MTLO
  // may arrive then; both are dropped by the logic above.
  always_ff @(posedge clk) begin
    if (PROTOCOL_CHECK && !reset && busy) begin
      assert (!start);
      assert (!(hi_we || lo_we));
    end
  end

endmodule
